// File: rtl/rcc_clk_div_dyn.sv
// Runtime-reprogrammable integer clock divider; the ratio is loaded via a 4-phase req/ack handshake.
// Define RCC_CLK_DIV_PULSE_EN to add the div_pulse clock-enable strobe output.
module rcc_clk_div_dyn #(
    parameter int RATIO_WID = 6,
    parameter int RST_RATIO = 0
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 upd_req,
    input  logic [RATIO_WID-1:0] upd_ratio,
    output logic                 upd_ack,
    output logic [RATIO_WID-1:0] cur_ratio,
    output logic                 o_clk,
    output logic                 div_en
`ifdef RCC_CLK_DIV_PULSE_EN
    ,
    output logic                 div_pulse
`endif
);

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam logic [RATIO_WID-1:0] ONE       = RATIO_WID'(1);
    localparam logic [RATIO_WID-1:0] TWO       = RATIO_WID'(2);
    localparam logic [RATIO_WID-1:0] RST_N_VAL = RATIO_WID'(RST_RATIO);
    localparam bit                   RST_RUN   = (RST_RATIO >= 2);
    localparam logic [RATIO_WID-1:0] RST_CNT   = RST_RUN ? (RST_N_VAL - ONE) : '0;

    state_t               state;
    logic [RATIO_WID-1:0] cnt;
    logic [RATIO_WID-1:0] cnt_inc;
    logic [RATIO_WID-1:0] half;
    logic                 pending;
    logic                 boundary;
    logic                 new_run;

    always_comb begin
        cnt_inc  = cnt + ONE;
        half     = cur_ratio >> 1;
        pending  = upd_req && !upd_ack;
        boundary = (cnt == (cur_ratio - ONE));
        new_run  = (upd_ratio >= TWO);
    end

    // A ratio change is only taken at a period boundary while running, so no runt pulse appears.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_RUN ? RUN : OFF;
            cnt       <= RST_CNT;
            cur_ratio <= RST_N_VAL;
            o_clk     <= 1'b0;
            upd_ack   <= 1'b0;
            div_en    <= RST_RUN;
        end else begin
            if (upd_ack && !upd_req) begin
                upd_ack <= 1'b0;
            end
            if (pending && (state == OFF || boundary)) begin
                cur_ratio <= upd_ratio;
                upd_ack   <= 1'b1;
                if (new_run) begin
                    state  <= RUN;
                    div_en <= 1'b1;
                    cnt    <= '0;
                    o_clk  <= 1'b1;
                end else begin
                    state  <= OFF;
                    div_en <= 1'b0;
                    o_clk  <= 1'b0;
                end
            end else if (state == RUN) begin
                if (boundary) begin
                    cnt   <= '0;
                    o_clk <= 1'b1;
                end else begin
                    cnt   <= cnt_inc;
                    o_clk <= (cnt_inc < half);
                end
            end
        end
    end

`ifdef RCC_CLK_DIV_PULSE_EN
    assign div_pulse = (state == RUN) && (cnt == '0);
`endif

endmodule

// File: doc/rcc_clk_div_dyn.md
# rcc_clk_div_dyn

Runtime-reprogrammable integer clock divider for RCC kernel and RTC clock branches. It divides `i_clk` by a ratio loaded through a 4-phase req/ack handshake. A new ratio takes effect only at a period boundary, so no runt pulse is produced on a ratio change. Ratio 0 or 1 parks the output low. Inputs are synchronous to `i_clk`; any CDC synchroniser sits upstream in the caller.

## Interface
- `RATIO_WID`, 6: width of ratio and period counter; legal divide range is 2..2^RATIO_WID-1.
- `RST_RATIO`, 0: ratio value loaded at reset; a value of 2 or more starts the divider running after reset.

- `i_clk`  in  1  source clock; the only clock in the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `upd_req`  in  1  ratio update request, level, 4-phase.
- `upd_ratio`  in  RATIO_WID  new ratio; held stable while `upd_req`=1.
- `upd_ack`  out  1  update acknowledge, level, 4-phase.
- `cur_ratio`  out  RATIO_WID  ratio currently in effect (shadow register).
- `o_clk`  out  1  divided clock, driven directly from a flop.
- `div_en`  out  1  1 while the divider is running.
- `div_pulse`  out  1  present only when `RCC_CLK_DIV_PULSE_EN` is defined.

## Operation
- Notation: N = `cur_ratio`, H = N>>1 (high-phase length), cnt = RATIO_WID-bit period counter.
- FSM states:
  - OFF: `div_en`=0, `o_clk`=0, cnt held.
  - RUN: `div_en`=1.
- RUN counting: each cycle, cnt <= (cnt==N-1) ? 0 : cnt+1; `o_clk` <= (cnt_next < H).
  - Even N gives 50% duty.
  - Odd N gives high for (N-1)/2 cycles and low for (N+1)/2 cycles.
- Period boundary: the RUN cycle with cnt==N-1. `o_clk` is low there and rises at the next edge.
- Pending request: `upd_req`=1 && `upd_ack`=0.
- Accept in OFF: a pending request is taken at the next edge.
- Accept in RUN: a pending request is taken only at the edge ending a boundary cycle.
- On accept:
  - `cur_ratio` <= `upd_ratio`; `upd_ack` <= 1.
  - If `upd_ratio` >= 2: state RUN, cnt <= 0, `o_clk` <= 1.
  - Else: state OFF, `o_clk` <= 0.
- Boundary without a pending request: cnt <= 0, `o_clk` <= 1.
- Handshake release: `upd_ack` stays 1 until `upd_req` is sampled 0, then `upd_ack` <= 0. A new request is recognised only once both are 0.
- Arithmetic: cnt never exceeds N-1, so no wrap past 2^RATIO_WID-1. Comparisons are unsigned, all RATIO_WID bits wide.
- Rewriting the same ratio is legal: it is acked at the boundary with no phase disturbance.
- `upd_req` falling before `upd_ack` rises is a protocol violation; behaviour in that case is not guaranteed.

## Timing
- Reset values:
  - `o_clk`=0, `upd_ack`=0, `cur_ratio`=`RST_RATIO`, `div_pulse`=0.
  - If `RST_RATIO` >= 2: state RUN, cnt=N-1, `div_en`=1, so the first edge after reset release raises `o_clk`.
  - Otherwise: state OFF, cnt=0, `div_en`=0.
- Asserting `rst_n` mid-operation forces all of the above immediately, asynchronously. Any in-flight handshake is dropped.
- Accept latency:
  - OFF: 1 cycle from `upd_req` sampled high to `upd_ack`/`o_clk` high.
  - RUN: at most N cycles.
- `div_en` and `o_clk` change on the same edge. `div_en` falls together with the last `o_clk` low transition into OFF.
- Handshake cycle minimum is 4 `i_clk` edges in OFF.

## Configuration
- `RCC_CLK_DIV_PULSE_EN` defined: adds output `div_pulse`, a 1-cycle strobe equal to (state==RUN && cnt==0). It is high for exactly the `i_clk` cycle in which `o_clk` has just risen; it is used as a clock-enable by same-domain logic.
- `RCC_CLK_DIV_PULSE_EN` undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- Even ratio from OFF: `RST_RATIO`=0, request ratio 4 → `upd_ack`=1 and `o_clk`=1 on the next edge; `o_clk` then repeats 1,1,0,0 with `div_en`=1.
- Odd ratio: request 5 → `o_clk` high 2 / low 3 cycles; with `RCC_CLK_DIV_PULSE_EN`, `div_pulse` pulses every 5 cycles.
- Ratio change mid-period: running at 4, request 3 at cnt=1 → no ack until the cnt==3 boundary; then pattern 1,0,0 with no runt pulse.
- Disable: running at 6, request 1 → current period completes, `o_clk`=0, `div_en`=0, `upd_ack`=1; ratio 0 behaves identically.
- Maximum ratio: `RATIO_WID`=6, request 63 → high 31 / low 32 cycles; cnt peaks at 62.
- Reset behaviour, two parts:
  - Assert `rst_n` during a high phase → `o_clk`, `upd_ack` and `div_en` drop immediately.
  - With `RST_RATIO`=2 → after reset release, `o_clk` toggles 1,0 from the first edge.
